// File: rtl/edge_row_scheduler.sv
// Frame-level scheduler for the edge-measurement path: sweeps edge_row one step per frame and
// streams each captured measured_list as a valid/ready burst. Optional macro: EDGE_SCHED_GAP_EN.
module edge_row_scheduler #(
    parameter int ROW_START = 40,
    parameter int ROW_END   = 440,
    parameter int ROW_STEP  = 40,
    parameter int LIST_LEN  = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     sop,
    input  logic                     packet_video,
    input  logic [LIST_LEN-1:0][10:0] measured_list,
    output logic [10:0]              edge_row,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic                     sweep_done,
    output logic                     busy
);

    typedef logic [LIST_LEN-1:0][10:0] list_t;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    list_t       snap_r;
    logic [10:0] tag_row_r;
    logic [4:0]  tag_sweep_r;
    logic [4:0]  sweep_r;
    logic [4:0]  idx_r;
    logic [4:0]  next_idx_s;
    logic [11:0] sum_s;
    logic        wrap_s;
    logic        fs_s;
    logic        hs_s;
    logic        capture_s;
    logic        last_hs_s;
    logic        ovf_set_s;

    // x field of word i: absolute position, or the gap to the previous edge in the gap build
    function automatic logic [10:0] x_of(input list_t lst, input logic [4:0] i);
`ifdef EDGE_SCHED_GAP_EN
        if (i == 5'd0) begin
            x_of = lst[0];
        end else begin
            x_of = lst[i] - lst[i - 5'd1];
        end
`else
        x_of = lst[i];
`endif
    endfunction

    // Word i closes the burst at the list end, on a zero-edge frame, or before the first zero
    function automatic logic is_last(input list_t lst, input logic [4:0] i);
        if (i == 5'(LIST_LEN - 1)) begin
            is_last = 1'b1;
        end else if (lst[i] == 11'd0) begin
            is_last = 1'b1;
        end else begin
            is_last = (lst[i + 5'd1] == 11'd0);
        end
    endfunction

    assign fs_s       = sop & packet_video;
    assign hs_s       = out_valid & out_ready;
    assign next_idx_s = idx_r + 5'd1;
    assign sum_s      = {1'b0, edge_row} + 12'(ROW_STEP);
    assign wrap_s     = (sum_s > 12'(ROW_END));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_next_s = ST_PRIME;
                else        state_next_s = ST_IDLE;
            end
            ST_PRIME: begin
                if (!enable)   state_next_s = ST_IDLE;
                else if (fs_s) state_next_s = ST_WAIT;
                else           state_next_s = ST_PRIME;
            end
            ST_WAIT: begin
                if (fs_s)         state_next_s = ST_DRAIN;
                else if (!enable) state_next_s = ST_IDLE;
                else              state_next_s = ST_WAIT;
            end
            ST_DRAIN: begin
                if (hs_s && out_last) state_next_s = enable ? ST_WAIT : ST_IDLE;
                else                  state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM control strobes; an fs arriving with the final handshake still counts as a DRAIN drop
    always_comb begin
        capture_s = 1'b0;
        last_hs_s = 1'b0;
        ovf_set_s = 1'b0;
        case (state_r)
            ST_WAIT: begin
                capture_s = fs_s;
            end
            ST_DRAIN: begin
                last_hs_s = hs_s & out_last;
                ovf_set_s = fs_s;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
    end

    // Snapshot, row sweep and output word pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_r      <= '0;
            tag_row_r   <= 11'd0;
            tag_sweep_r <= 5'd0;
            sweep_r     <= 5'd0;
            idx_r       <= 5'd0;
            edge_row    <= 11'(ROW_START);
            out_data    <= 32'd0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            overflow    <= 1'b0;
            sweep_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            busy       <= (state_next_s == ST_DRAIN);
            if (ovf_set_s) begin
                overflow <= 1'b1;
            end
            if (capture_s) begin
                snap_r      <= measured_list;
                tag_row_r   <= edge_row;
                tag_sweep_r <= sweep_r;
                idx_r       <= 5'd0;
                out_data    <= {sweep_r, edge_row, 5'd0, measured_list[0]};
                out_last    <= is_last(measured_list, 5'd0);
                out_valid   <= 1'b1;
                if (wrap_s) begin
                    edge_row   <= 11'(ROW_START);
                    sweep_r    <= sweep_r + 5'd1;
                    sweep_done <= 1'b1;
                end else begin
                    edge_row <= sum_s[10:0];
                end
            end else if (last_hs_s) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_data  <= 32'd0;
            end else if (hs_s) begin
                idx_r    <= next_idx_s;
                out_data <= {tag_sweep_r, tag_row_r, next_idx_s, x_of(snap_r, next_idx_s)};
                out_last <= is_last(snap_r, next_idx_s);
            end
        end
    end

endmodule

// File: doc/edge_row_scheduler.md
Name: edge_row_scheduler

Overview:
- Frame-level controller for the processing block's edge-measurement path.
- Drives `edge_row` so the measured row sweeps down the image, one row per video frame.
- At each video start-of-packet it snapshots `measured_list`, before the processing block clears it, and streams the recorded edge x-positions to the host message FIFO over a valid/ready interface.

Parameters:
- ROW_START, 40, first row of the sweep and reset value of `edge_row`.
- ROW_END, 440, last permitted row; ROW_START <= ROW_END < 480.
- ROW_STEP, 40, row increment per captured frame; must be >= 1.
- LIST_LEN, 30, entries in `measured_list`.

Ports:
- clk  in  1  pixel clock, shared with the processing block.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = schedule/capture, 0 = idle after current drain.
- sop  in  1  start-of-packet from the video stream.
- packet_video  in  1  qualifies `sop` as a video packet.
- measured_list  in  30x11  edge x-positions from the processing block; a 0 entry means unused.
- edge_row  out  11  row the processing block measures.
- out_data  out  32  {sweep[4:0], row[10:0], idx[4:0], x[10:0]}.
- out_valid  out  1  `out_data` is valid.
- out_last  out  1  last word of the current row's burst.
- out_ready  in  1  sink accepts the word when out_valid and out_ready are both 1.
- overflow  out  1  sticky; a frame's list was dropped while draining. Cleared only by reset.
- sweep_done  out  1  one-cycle pulse when `edge_row` wraps.
- busy  out  1  1 while in DRAIN.

Behaviour:
- Reset values:
  - edge_row = ROW_START.
  - out_data, out_valid, out_last, overflow, sweep_done, busy = 0.
  - sweep counter = 0; state = IDLE.
- Frame event: `fs = sop & packet_video`, sampled on `clk`.
- `measured_list` is sampled on the fs cycle itself. It still holds the previous frame's values on that edge.
- FSM states:
  - IDLE:
    - enable=1 -> PRIME.
  - PRIME:
    - Waits for the first fs. That list was measured before scheduling began, so it is discarded.
    - On fs -> WAIT. `edge_row` is unchanged.
    - enable=0 -> IDLE.
  - WAIT:
    - On fs: snapshot all LIST_LEN entries; tag_row = edge_row; advance edge_row; go to DRAIN with idx=0.
    - enable=0 (no fs) -> IDLE.
  - DRAIN:
    - out_valid is asserted the cycle after the fs capture. Throughput is 1 word/cycle while out_ready=1.
    - Word idx carries snapshot[idx].
    - Burst ends at the first zero entry or at idx = LIST_LEN-1; out_last=1 on that word.
    - Zero-edge frame (snapshot[0]=0): emit exactly one word with x=0, idx=0, out_last=1.
    - After the out_last handshake: enable=1 -> WAIT, else -> IDLE.
- Advance rule:
  - If edge_row + ROW_STEP > ROW_END: edge_row = ROW_START, sweep counter +1 (wraps at 32), sweep_done pulses the cycle after fs.
  - Otherwise edge_row += ROW_STEP.
  - Compute the sum at 12 bits to avoid wrap.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
  - out_valid never deasserts without a handshake.
- fs during DRAIN:
  - Snapshot is not replaced; overflow is set; edge_row does not advance.
  - The frame now in progress rescans the same row, which is captured at the following fs.
- fs coincident with the final (out_last) handshake counts as "during DRAIN".
- enable deasserted mid-DRAIN: the burst completes, then the FSM goes to IDLE. Re-enabling restarts from PRIME; edge_row retains its value.
- sop with packet_video=0 is ignored in every state.
- reset mid-burst: all outputs clear immediately and asynchronously; no partial burst resumes.

Optional Feature:
- Macro: EDGE_SCHED_GAP_EN.
- Defined: for idx>0, out_data[10:0] = snapshot[idx] - snapshot[idx-1], an 11-bit unsigned gap (object width in pixels). idx=0 still carries the absolute x.
- Undefined: every word carries the absolute x.
- Burst length, termination and handshake are identical in both builds.

Test Plan:
- Bring-up: reset, enable=1, first fs with list={100,200,0...} -> no output; edge_row stays 40.
- Capture: list={100,200,350,0...}, fs in WAIT, out_ready=1.
  - -> 3 words, rows=40, idx 0..2, x=100,200,350, out_last on idx 2.
  - -> edge_row=80 the cycle after fs.
- Backpressure: same list, out_ready toggles 1,0,0,1 -> out_data stable during stalls; still exactly 3 words in order.
- Full list and zero list:
  - 30 nonzero entries -> 30 words, out_last on idx 29.
  - All-zero list -> 1 word, x=0, out_last=1.
- Wrap: edge_row=440, fs in WAIT -> edge_row=40, sweep_done pulses 1 cycle, next burst has sweep=1.
- Overflow: out_ready=0, then fs during DRAIN -> overflow=1, edge_row unchanged. Next fs after the drain emits that row's tag. With EDGE_SCHED_GAP_EN, list {100,200,350} -> x fields 100,100,150.
